// File: rtl/arquitetura_pio_pkg.sv
// Shared definitions for the status-input PIO: register word offsets.
package arquitetura_pio_pkg;

    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned BUS_W   = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_RSVD    = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

endpackage

// File: rtl/arquitetura_sync_edge.sv
// Multi-stage synchronizer for asynchronous status lines plus rising-edge detect.
module arquitetura_sync_edge #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // Shift the inputs through the synchronizer chain and keep a one-cycle-old copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Last synchronizer stage is the safe view; a rise is 1 now and 0 a cycle ago.
    always_comb begin
        q    = sync_q[SYNC_STAGES-1];
        rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

endmodule

// File: rtl/arquitetura_status_in.sv
// Avalon-MM status-input PIO: synchronized data, interrupt mask, W1C edge capture.
module arquitetura_status_in
    import arquitetura_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [BUS_W-1:0]  writedata,
    output logic [BUS_W-1:0]  readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic             wr_en;
    logic [WIDTH-1:0] clr_mask;

    arquitetura_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync_q),
        .rise    (rise)
    );

    // Decode writes; clearing is applied before setting so a coincident rise wins.
    always_comb begin
        wr_en     = chipselect & ~write_n;
        irqmask_d = irqmask_q;
        clr_mask  = '0;
        if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGECAP) begin
            clr_mask = writedata[WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~clr_mask) | rise;
    end

    // Register state: mask and capture both drop to zero on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    // Zero-wait-state read mux driven by address alone; unused upper bits read 0.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = sync_q;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
            default:      readdata = '0;
        endcase
    end

    // Level interrupt from registered capture and mask.
    always_comb begin
        irq = |(edgecap_q & irqmask_q);
    end

endmodule
